// File: rtl/fifo_demux_buf.sv
// Show-ahead FIFO: one-hot write demux into entry registers, pointer-indexed read mux.
// Define FIFO_ERR_FLAG_EN to add sticky overflow/underflow flags on o_err.
module fifo_demux_buf #(
  parameter int unsigned bw     = 8,
  parameter int unsigned depth  = 16,
  parameter int unsigned ptr_bw = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [bw-1:0] in,
  input  logic          wr,
  input  logic          rd,
  output logic [bw-1:0] out,
  output logic          o_full,
  output logic          o_empty
`ifdef FIFO_ERR_FLAG_EN
  ,
  output logic [1:0]    o_err
`endif
);

  localparam int unsigned pw = ptr_bw + 1;

  logic [pw-1:0]    wr_ptr;
  logic [pw-1:0]    rd_ptr;
  logic [bw-1:0]    q [depth];
  logic [depth-1:0] wr_sel;
  logic             push_ok;
  logic             pop_ok;

  // Flags come only from registered pointers; the MSB is the wrap bit.
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[ptr_bw-1:0] == rd_ptr[ptr_bw-1:0]) &&
                   (wr_ptr[ptr_bw] != rd_ptr[ptr_bw]);

  // A full FIFO still takes a push when a pop frees the head slot this cycle.
  assign push_ok = wr & (~o_full | rd);
  assign pop_ok  = rd & ~o_empty;

  // One-hot write demux: at most one entry loads per push.
  always_comb begin
    wr_sel = '0;
    wr_sel[wr_ptr[ptr_bw-1:0]] = push_ok;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(depth); i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(depth); i++) begin
        if (wr_sel[i]) q[i] <= in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + pw'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + pw'(1);
    end
  end

  // Show-ahead head word; stale when empty.
  assign out = q[rd_ptr[ptr_bw-1:0]];

`ifdef FIFO_ERR_FLAG_EN
  // Sticky: [0] write dropped while full, [1] read while empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_err <= 2'b00;
    end else begin
      if (wr & o_full & ~rd) o_err[0] <= 1'b1;
      if (rd & o_empty)      o_err[1] <= 1'b1;
    end
  end
`endif

endmodule
